lvds_rx_align_ctrl: RTL
=======================

Name: lvds_rx_align_ctrl

Overview:
- Training sequencer for the LVDS receive link, clocked in the CLKDIV domain next to lvds_phy_rx.
- Commands the transmitter to send the training pattern.
- Drives the receiver's COMP_VAL and INIT_REQ inputs and watches its per-lane BIT_ALIGN/BYTE_ALIGN flags.
- Retries on timeout, declares LINK_UP after a stable lock, and handles loss of alignment.

Parameters:
C_LANE_NUM, 2, number of LVDS data lanes
C_TRAIN_PATTERN, 8'b01010101, value driven on COMP_VAL_O
C_SETTLE_CYC, 16, cycles TRAIN_EN_O is held before the first INIT_REQ (range 1..65535)
C_REQ_PULSE_CYC, 1, INIT_REQ_O high width in cycles (range 1..15)
C_TIMEOUT_CYC, 1024, max cycles in WAIT_ALIGN per attempt (range 2..65535)
C_MAX_RETRY, 4, attempts before FAIL (range 1..15)
C_LOCK_CNT, 8, consecutive all-aligned cycles required for LINK_UP (range 1..255)

Ports:
CLKDIV_I  in  1  block clock, same clock as lvds_phy_rx CLKDIV_I
CLKDIV_RST_I  in  1  reset, synchronous, active-high
START_I  in  1  single-cycle request to (re)start training
BIT_ALIGN_I  in  C_LANE_NUM  per-lane bit-align flag from the receiver
BYTE_ALIGN_I  in  C_LANE_NUM  per-lane byte-align flag from the receiver
TRAIN_EN_O  out  1  transmitter sends C_TRAIN_PATTERN while high
COMP_VAL_O  out  8  compare pattern to the receiver; constant C_TRAIN_PATTERN
INIT_REQ_O  out  1  align request pulse to the receiver
LINK_UP_O  out  1  link trained and locked
FAIL_O  out  1  training exhausted retries (sticky)
RETRY_CNT_O  out  4  attempts that have timed out since the last start
LANE_ERR_O  out  C_LANE_NUM  lanes not aligned at the last timeout or loss event
STATE_O  out  3  encoded state: IDLE=0 SETTLE=1 REQ=2 WAIT=3 LOCK=4 UP=5 FAIL=6

Behaviour:
- All outputs are registered. A transition takes effect on the clock edge after its qualifying condition.
- Reset values: STATE_O=IDLE; TRAIN_EN_O, INIT_REQ_O, LINK_UP_O, FAIL_O=0; RETRY_CNT_O=0; LANE_ERR_O=0. COMP_VAL_O=C_TRAIN_PATTERN always, including in reset.
- Reset mid-operation returns to IDLE on the next edge, with all counters cleared.
- Aligned condition: all_ok = &(BIT_ALIGN_I & BYTE_ALIGN_I).
- IDLE: outputs inactive. START_I goes to SETTLE and clears RETRY_CNT_O and LANE_ERR_O.
- SETTLE: TRAIN_EN_O=1. Held for exactly C_SETTLE_CYC cycles, then goes to REQ.
- REQ: TRAIN_EN_O=1, INIT_REQ_O=1 for exactly C_REQ_PULSE_CYC cycles. Then goes to WAIT, with the timeout counter cleared.
- WAIT: TRAIN_EN_O=1. The timeout counter increments every cycle.
  - all_ok goes to LOCK, with the lock counter cleared.
  - The counter reaching C_TIMEOUT_CYC-1 without all_ok is a timeout:
    - LANE_ERR_O <= ~(BIT_ALIGN_I & BYTE_ALIGN_I) and RETRY_CNT_O increments.
    - If the new count equals C_MAX_RETRY, go to FAIL; otherwise go to REQ.
  - If all_ok and timeout coincide, all_ok wins and goes to LOCK.
- LOCK: TRAIN_EN_O=1. The lock counter increments while all_ok.
  - all_ok for C_LOCK_CNT consecutive cycles (counted including the entry cycle) goes to UP.
  - Any cycle without all_ok returns to WAIT. The timeout counter is NOT cleared, so the total attempt time stays bounded.
- UP: LINK_UP_O=1, TRAIN_EN_O=0. !all_ok is a loss event: LANE_ERR_O is captured and LINK_UP_O drops on the next edge. The next state depends on the optional feature.
- FAIL: FAIL_O=1, TRAIN_EN_O=0. Sticky until START_I, which behaves as from IDLE (goes to SETTLE and clears FAIL_O, RETRY_CNT_O, LANE_ERR_O), or until reset.
- START_I handling:
  - Ignored in SETTLE, REQ, WAIT and LOCK.
  - In UP it forces retraining: go to SETTLE, LINK_UP_O=0, counters cleared.
  - If START_I coincides with a loss event in UP, START_I wins (SETTLE, counters cleared).
- Counters saturate and never wrap. RETRY_CNT_O can never exceed C_MAX_RETRY.

Optional Feature:
- Macro LVDS_ALIGN_AUTO_RETRAIN_EN.
- Defined: a loss event in UP goes to SETTLE and clears RETRY_CNT_O. LANE_ERR_O keeps the captured loss value until the next timeout or START_I.
- Undefined: a loss event in UP goes to FAIL (FAIL_O=1), leaving the link down until START_I.

Test Plan:
Bench parameters for all scenarios: C_SETTLE_CYC=4, C_REQ_PULSE_CYC=1, C_TIMEOUT_CYC=32, C_MAX_RETRY=3, C_LOCK_CNT=4, C_LANE_NUM=2.
1. Reset, then START_I pulse; both lanes' flags go to 2'b11 three cycles after INIT_REQ_O falls -> TRAIN_EN_O high 4 cycles before a 1-cycle INIT_REQ_O; LINK_UP_O rises 4 cycles after all_ok; TRAIN_EN_O then 0; RETRY_CNT_O=0.
2. Lane 1 never aligns (BIT=2'b01, BYTE=2'b01) -> three INIT_REQ_O pulses spaced 33 cycles apart; RETRY_CNT_O 1,2,3; FAIL_O=1; LANE_ERR_O=2'b10; STATE_O=6; a later START_I clears FAIL_O and restarts SETTLE.
3. all_ok for 2 cycles, drops 1 cycle, then stays high -> LOCK returns to WAIT without a new INIT_REQ_O; LINK_UP_O follows 4 cycles after re-lock; no retry counted.
4. In UP, lane 0 BYTE_ALIGN drops for 1 cycle -> LINK_UP_O=0 next edge, LANE_ERR_O=2'b01. With the macro: STATE_O=1 and retraining runs. Without the macro: FAIL_O=1.
5. START_I asserted in WAIT mid-attempt -> ignored. START_I in UP on the same cycle as a loss event -> SETTLE with counters cleared.
6. CLKDIV_RST_I asserted for 1 cycle during REQ -> INIT_REQ_O=0 and STATE_O=0 on the next edge; COMP_VAL_O stays 8'b01010101 throughout.

Source files
------------

// File: rtl/lvds_rx_align_if.sv
// Signal bundle between the LVDS training sequencer and the receiver/transmitter side.
// master = sequencer (lvds_rx_align_ctrl), slave = receiver/transmitter side.
interface lvds_rx_align_if #(
  parameter int C_LANE_NUM = 2
);
  logic                  START_I;
  logic [C_LANE_NUM-1:0] BIT_ALIGN_I;
  logic [C_LANE_NUM-1:0] BYTE_ALIGN_I;
  logic                  TRAIN_EN_O;
  logic [7:0]            COMP_VAL_O;
  logic                  INIT_REQ_O;
  logic                  LINK_UP_O;
  logic                  FAIL_O;
  logic [3:0]            RETRY_CNT_O;
  logic [C_LANE_NUM-1:0] LANE_ERR_O;
  logic [2:0]            STATE_O;

  modport master (
    input  START_I, BIT_ALIGN_I, BYTE_ALIGN_I,
    output TRAIN_EN_O, COMP_VAL_O, INIT_REQ_O, LINK_UP_O, FAIL_O,
           RETRY_CNT_O, LANE_ERR_O, STATE_O
  );

  modport slave (
    output START_I, BIT_ALIGN_I, BYTE_ALIGN_I,
    input  TRAIN_EN_O, COMP_VAL_O, INIT_REQ_O, LINK_UP_O, FAIL_O,
           RETRY_CNT_O, LANE_ERR_O, STATE_O
  );
endinterface

// File: rtl/lvds_rx_align_ctrl.sv
// LVDS receive-link training sequencer (CLKDIV domain): settle, align request, lock, link-up.
// Optional macro LVDS_ALIGN_AUTO_RETRAIN_EN: loss of lock in UP retrains instead of failing.
module lvds_rx_align_ctrl #(
  parameter int         C_LANE_NUM      = 2,
  parameter logic [7:0] C_TRAIN_PATTERN = 8'b01010101,
  parameter int         C_SETTLE_CYC    = 16,
  parameter int         C_REQ_PULSE_CYC = 1,
  parameter int         C_TIMEOUT_CYC   = 1024,
  parameter int         C_MAX_RETRY     = 4,
  parameter int         C_LOCK_CNT      = 8
) (
  input  logic           CLKDIV_I,
  input  logic           CLKDIV_RST_I,
  lvds_rx_align_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_LOCK   = 3'd4,
    S_UP     = 3'd5,
    S_FAIL   = 3'd6
  } state_e;

  localparam logic [15:0] SETTLE_LAST = 16'(C_SETTLE_CYC - 1);
  localparam logic [15:0] REQ_LAST    = 16'(C_REQ_PULSE_CYC - 1);
  localparam logic [15:0] TMO_LAST    = 16'(C_TIMEOUT_CYC - 1);
  localparam logic [7:0]  LOCK_LAST   = 8'(C_LOCK_CNT - 1);
  localparam logic [3:0]  MAX_RETRY   = 4'(C_MAX_RETRY);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           tmo_q, tmo_d;
  logic [7:0]            lock_q, lock_d;
  logic [3:0]            retry_q, retry_d;
  logic [C_LANE_NUM-1:0] lane_err_q, lane_err_d;
  logic                  train_en_q, train_en_d;
  logic                  init_req_q, init_req_d;
  logic                  link_up_q, link_up_d;
  logic                  fail_q, fail_d;

  logic [C_LANE_NUM-1:0] aligned_s;
  logic                  all_ok_s;
  logic                  restart_s;
  logic [3:0]            retry_inc_s;

  assign aligned_s   = bus.BIT_ALIGN_I & bus.BYTE_ALIGN_I;
  assign all_ok_s    = &aligned_s;
  // START_I only acts from the resting states; in UP it also beats a simultaneous loss event.
  assign restart_s   = bus.START_I && ((state_q == S_IDLE) || (state_q == S_UP) || (state_q == S_FAIL));
  assign retry_inc_s = (retry_q == MAX_RETRY) ? retry_q : retry_q + 4'd1;

  // Next-state, counter and output-register logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    lock_d     = lock_q;
    retry_d    = retry_q;
    lane_err_d = lane_err_q;

    case (state_q)
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_REQ;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_REQ: begin
        if (cnt_q == REQ_LAST) begin
          state_d = S_WAIT;
          tmo_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        tmo_d = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 16'd1;
        if (all_ok_s) begin
          state_d = S_LOCK;
          lock_d  = 8'd0;
        end else if (tmo_q == TMO_LAST) begin
          lane_err_d = ~aligned_s;
          retry_d    = retry_inc_s;
          if (retry_inc_s == MAX_RETRY) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_REQ;
            cnt_d   = 16'd0;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_LOCK: begin
        // Dropping back to WAIT keeps the timeout counter so one attempt stays bounded.
        if (!all_ok_s) begin
          state_d = S_WAIT;
        end else if (lock_q == LOCK_LAST) begin
          state_d = S_UP;
        end else begin
          lock_d = lock_q + 8'd1;
        end
      end
      S_UP: begin
        if (!all_ok_s) begin
          lane_err_d = ~aligned_s;
`ifdef LVDS_ALIGN_AUTO_RETRAIN_EN
          state_d = S_SETTLE;
          cnt_d   = 16'd0;
          tmo_d   = 16'd0;
          lock_d  = 8'd0;
          retry_d = 4'd0;
`else
          state_d = S_FAIL;
`endif
        end else begin
          state_d = S_UP;
        end
      end
      S_IDLE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase

    if (restart_s) begin
      state_d    = S_SETTLE;
      cnt_d      = 16'd0;
      tmo_d      = 16'd0;
      lock_d     = 8'd0;
      retry_d    = 4'd0;
      lane_err_d = '0;
    end else begin
      lane_err_d = lane_err_d;
    end

    train_en_d = (state_d == S_SETTLE) || (state_d == S_REQ) ||
                 (state_d == S_WAIT)   || (state_d == S_LOCK);
    init_req_d = (state_d == S_REQ);
    link_up_d  = (state_d == S_UP);
    fail_d     = (state_d == S_FAIL);
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge CLKDIV_I) begin
    if (CLKDIV_RST_I) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      tmo_q      <= 16'd0;
      lock_q     <= 8'd0;
      retry_q    <= 4'd0;
      lane_err_q <= '0;
      train_en_q <= 1'b0;
      init_req_q <= 1'b0;
      link_up_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      lock_q     <= lock_d;
      retry_q    <= retry_d;
      lane_err_q <= lane_err_d;
      train_en_q <= train_en_d;
      init_req_q <= init_req_d;
      link_up_q  <= link_up_d;
      fail_q     <= fail_d;
    end
  end

  assign bus.COMP_VAL_O  = C_TRAIN_PATTERN;
  assign bus.STATE_O     = state_q;
  assign bus.TRAIN_EN_O  = train_en_q;
  assign bus.INIT_REQ_O  = init_req_q;
  assign bus.LINK_UP_O   = link_up_q;
  assign bus.FAIL_O      = fail_q;
  assign bus.RETRY_CNT_O = retry_q;
  assign bus.LANE_ERR_O  = lane_err_q;

endmodule
